// File: rtl/register_writeback.sv
// register_writeback: queues ALU/load results and writes them to the 1W/2R register file.
// Keeps a per-register pending scoreboard for RAW stalls. Optional macro: WB_BYPASS_EN.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   alu_valid/alu_rd/alu_data        ALU result offer; alu_ready accepts
//   mem_valid/mem_rd/mem_data        load result offer; mem_ready accepts (priority over ALU)
//   wb_stall                         hold the queue, no pop while high
//   issue_claim/issue_rd             mark issue_rd as having a write outstanding
//   pending                          bit i = write to register i outstanding
//   register_write/write_data        register file write address/data (registered)
//   register_write_enable            one-cycle write strobe per entry
//
// WB_BYPASS_EN: when the queue is empty and not stalled, an accepted entry is loaded
// straight into the output registers (latency 1) instead of passing through the queue.
module register_writeback #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_valid,
    input  logic [REG_ADDR_WIDTH-1:0]    alu_rd,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    output logic                         alu_ready,
    input  logic                         mem_valid,
    input  logic [REG_ADDR_WIDTH-1:0]    mem_rd,
    input  logic [DATA_WIDTH-1:0]        mem_data,
    output logic                         mem_ready,
    input  logic                         wb_stall,
    input  logic                         issue_claim,
    input  logic [REG_ADDR_WIDTH-1:0]    issue_rd,
    output logic [2**REG_ADDR_WIDTH-1:0] pending,
    output logic [REG_ADDR_WIDTH-1:0]    register_write,
    output logic [DATA_WIDTH-1:0]        write_data,
    output logic                         register_write_enable
);

    localparam int NUM_REGS = 2**REG_ADDR_WIDTH;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

    logic [REG_ADDR_WIDTH-1:0] r_q_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     r_q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wptr;
    logic [PTR_W-1:0]          r_rptr;
    logic [CNT_W-1:0]          r_count;
    logic [REG_ADDR_WIDTH-1:0] r_wa;
    logic [DATA_WIDTH-1:0]     r_wd;
    logic                      r_en;
    logic [NUM_REGS-1:0]       r_pending;

    logic                      w_room;
    logic                      w_take_mem;
    logic                      w_take_alu;
    logic                      w_acc;
    logic [REG_ADDR_WIDTH-1:0] w_in_rd;
    logic [DATA_WIDTH-1:0]     w_in_data;
    logic                      w_store_req;
    logic                      w_pop;
    logic                      w_bypass;
    logic                      w_push;
    logic [REG_ADDR_WIDTH-1:0] w_head_rd;
    logic [DATA_WIDTH-1:0]     w_head_data;
    logic [NUM_REGS-1:0]       w_pend_nxt;

    // Readies look only at the registered count, so a full queue
    // refuses even when a pop happens on the same edge.
    assign w_room     = (r_count < DEPTH);
    assign mem_ready  = w_room;
    assign alu_ready  = w_room & ~mem_valid;

    assign w_take_mem = mem_valid & w_room;
    assign w_take_alu = alu_valid & alu_ready;
    assign w_acc      = w_take_mem | w_take_alu;
    assign w_in_rd    = w_take_mem ? mem_rd : alu_rd;
    assign w_in_data  = w_take_mem ? mem_data : alu_data;

    // Writes to x0 complete the handshake but are discarded.
    assign w_store_req = w_acc & (w_in_rd != '0);
    assign w_pop       = (r_count != '0) & ~wb_stall;

`ifdef WB_BYPASS_EN
    assign w_bypass = w_store_req & (r_count == '0) & ~wb_stall;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push      = w_store_req & ~w_bypass;
    assign w_head_rd   = r_q_rd[r_rptr];
    assign w_head_data = r_q_data[r_rptr];

    // A claim on the same edge as the retiring write wins, since the
    // claim belongs to a younger instruction.
    always_comb begin
        w_pend_nxt = r_pending;
        if (w_pop) begin
            w_pend_nxt[w_head_rd] = 1'b0;
        end else if (w_bypass) begin
            w_pend_nxt[w_in_rd] = 1'b0;
        end
        if (issue_claim && (issue_rd != '0)) begin
            w_pend_nxt[issue_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_q_rd[i]   <= '0;
                r_q_data[i] <= '0;
            end
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_wa      <= '0;
            r_wd      <= '0;
            r_en      <= 1'b0;
            r_pending <= '0;
        end else begin
            if (w_push) begin
                r_q_rd[r_wptr]   <= w_in_rd;
                r_q_data[r_wptr] <= w_in_data;
                r_wptr           <= r_wptr + PTR_W'(1);
            end

            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
                r_wa   <= w_head_rd;
                r_wd   <= w_head_data;
                r_en   <= 1'b1;
            end else if (w_bypass) begin
                r_wa <= w_in_rd;
                r_wd <= w_in_data;
                r_en <= 1'b1;
            end else begin
                r_en <= 1'b0;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            r_pending <= w_pend_nxt;
        end
    end

    assign register_write        = r_wa;
    assign write_data            = r_wd;
    assign register_write_enable = r_en;
    assign pending               = r_pending;

endmodule

// File: tb/tb_register_writeback.sv
// tb_register_writeback: table vectors, directed corner sequences and a
// random run against a queue-based reference model.
module tb_register_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        wb_stall;
    logic        issue_claim;
    logic [4:0]  issue_rd;
    logic [31:0] pending;
    logic [4:0]  register_write;
    logic [31:0] write_data;
    logic        register_write_enable;

    register_writeback dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .alu_valid             (alu_valid),
        .alu_rd                (alu_rd),
        .alu_data              (alu_data),
        .alu_ready             (alu_ready),
        .mem_valid             (mem_valid),
        .mem_rd                (mem_rd),
        .mem_data              (mem_data),
        .mem_ready             (mem_ready),
        .wb_stall              (wb_stall),
        .issue_claim           (issue_claim),
        .issue_rd              (issue_rd),
        .pending               (pending),
        .register_write        (register_write),
        .write_data            (write_data),
        .register_write_enable (register_write_enable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        ar;
        logic        mr;
        logic        en;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    ent_t        q[$];
    logic        m_en;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [31:0] m_pend;
    logic        s_ar;
    logic        s_mr;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_en   = 1'b0;
        m_wa   = '0;
        m_wd   = '0;
        m_pend = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_rd      = '0;
        mem_data    = '0;
        wb_stall    = 1'b0;
        issue_claim = 1'b0;
        issue_rd    = '0;
        rst_n       = 1'b0;
        #1;
        chk("rst_en", register_write_enable, 0);
        chk("rst_wa", register_write, 0);
        chk("rst_wd", write_data, 0);
        chk("rst_pending", pending, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_mem_ready", mem_ready, 1);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, check readies before the edge, advance the
    // model by the transfer rules, check registered outputs after the edge.
    task automatic step(input logic av, input logic [4:0] ard,
                        input logic [31:0] ad, input logic mv,
                        input logic [4:0] mrd, input logic [31:0] md,
                        input logic st, input logic cl,
                        input logic [4:0] ird);
        int   sz;
        logic e_ar, e_mr, take_m, take_a, acc, pop, byp;
        ent_t in, hd;
        @(negedge clk);
        alu_valid   = av;
        alu_rd      = ard;
        alu_data    = ad;
        mem_valid   = mv;
        mem_rd      = mrd;
        mem_data    = md;
        wb_stall    = st;
        issue_claim = cl;
        issue_rd    = ird;
        #1;
        sz   = q.size();
        e_mr = (sz < 4);
        e_ar = e_mr && !mv;
        s_ar = alu_ready;
        s_mr = mem_ready;
        chk("alu_ready", alu_ready, e_ar);
        chk("mem_ready", mem_ready, e_mr);
        take_m  = mv && e_mr;
        take_a  = !take_m && av && e_ar;
        acc     = take_m || take_a;
        in.rd   = take_m ? mrd : ard;
        in.data = take_m ? md : ad;
        pop     = (sz != 0) && !st;
        byp     = 1'b0;
`ifdef WB_BYPASS_EN
        byp = acc && (in.rd != 0) && (sz == 0) && !st;
`endif
        @(posedge clk);
        #1;
        if (pop) begin
            hd = q.pop_front();
            m_en = 1'b1;
            m_wa = hd.rd;
            m_wd = hd.data;
            m_pend[hd.rd] = 1'b0;
        end else if (byp) begin
            m_en = 1'b1;
            m_wa = in.rd;
            m_wd = in.data;
            m_pend[in.rd] = 1'b0;
        end else begin
            m_en = 1'b0;
        end
        if (acc && (in.rd != 0) && !byp) q.push_back(in);
        if (cl && (ird != 0)) m_pend[ird] = 1'b1;
        chk("en", register_write_enable, m_en);
        chk("wa", register_write, m_wa);
        chk("wd", write_data, m_wd);
        chk("pending", pending, m_pend);
    endtask

    task automatic idle(input logic st);
        step(0, 0, 0, 0, 0, 0, st, 0, 0);
    endtask

    vec_t tbl[8];

    initial begin
        rst_n = 1'b0;
        model_clear();

        tbl[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 1, 0, 0, 32'h0};
        tbl[1] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 5, 32'hDEADBEEF};
        tbl[2] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 32'hDEADBEEF};
        tbl[3] = '{1, 3, 32'h33, 1, 4, 32'h44, 0, 1, 0, 5, 32'hDEADBEEF};
        tbl[4] = '{1, 3, 32'h33, 0, 0, 0, 1, 1, 1, 4, 32'h44};
        tbl[5] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 32'h33};
        tbl[6] = '{1, 0, 32'h1, 0, 0, 0, 1, 1, 0, 3, 32'h33};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 32'h33};

        do_reset();

`ifndef WB_BYPASS_EN
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].av, tbl[i].ard, tbl[i].ad,
                 tbl[i].mv, tbl[i].mrd, tbl[i].md, 0, 0, 0);
            chk($sformatf("tbl%0d_ar", i), s_ar, tbl[i].ar);
            chk($sformatf("tbl%0d_mr", i), s_mr, tbl[i].mr);
            chk($sformatf("tbl%0d_en", i), register_write_enable, tbl[i].en);
            chk($sformatf("tbl%0d_wa", i), register_write, tbl[i].wa);
            chk($sformatf("tbl%0d_wd", i), write_data, tbl[i].wd);
        end
`endif

        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step(1, 5'(i), 32'h100 + i, 0, 0, 0, 1, 0, 0);
        end
        step(1, 5, 32'h105, 0, 0, 0, 1, 0, 0);
        chk("full_alu_ready", s_ar, 0);
        chk("full_mem_ready", s_mr, 0);
        for (int i = 1; i <= 4; i++) begin
            idle(0);
            chk("drain_en", register_write_enable, 1);
            chk("drain_wa", register_write, i);
            chk("drain_wd", write_data, 32'h100 + i);
        end
        idle(0);
        chk("drain_done_en", register_write_enable, 0);

        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 1, 7);
        chk("claim7", pending[7], 1);
        step(1, 7, 32'h77, 0, 0, 0, 0, 0, 0);
        idle(0);
        chk("pop7_clear", pending[7], 0);
        step(1, 7, 32'h78, 0, 0, 0, 0, 1, 7);
        step(0, 0, 0, 0, 0, 0, 0, 1, 7);
        chk("pop7_claim_wins", pending[7], 1);
        chk("pop7_claim_en", register_write_enable, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("claim0_ignored", pending[0], 0);

        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i % 200 == 199) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)),
                     $urandom,
                     $urandom_range(0, 99) < 35, 5'($urandom_range(0, 7)),
                     $urandom,
                     $urandom_range(0, 99) < 30,
                     $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
